// File: rtl/cnn_pkg.sv
// Shared definitions for the kernel feeder slice.
//   KERNEL_TAPS    : weights per 3x3 kernel
//   WEIGHT_W       : weight word width
//   TAP_W          : width of tap / buffer index counters
//   feeder_state_t : kernel_feeder FSM state
package cnn_pkg;

    localparam int KERNEL_TAPS = 9;
    localparam int WEIGHT_W    = 16;
    localparam int TAP_W       = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DONE
    } feeder_state_t;

endpackage

// File: rtl/kernel_shadow_buf.sv
// Shadow register file holding one prefetched kernel (9 x 16-bit weights).
// Only instantiated when KERNEL_PREFETCH_EN is defined.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en/wr_idx/wr_data : write port, one weight per cycle
//   rd_idx/rd_data    : combinational read port
module kernel_shadow_buf
    import cnn_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [TAP_W-1:0]    wr_idx,
    input  logic [WEIGHT_W-1:0] wr_data,
    input  logic [TAP_W-1:0]    rd_idx,
    output logic [WEIGHT_W-1:0] rd_data
);

    logic [WEIGHT_W-1:0] regs [KERNEL_TAPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < KERNEL_TAPS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_idx < TAP_W'(KERNEL_TAPS))) begin
            regs[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_idx < TAP_W'(KERNEL_TAPS)) begin
            rd_data = regs[rd_idx];
        end
    end

endmodule

// File: rtl/kernel_feeder.sv
// Streams runs of 3x3 kernels from weight SRAM into a PE over its serial
// kernel-load port. One kernel is delivered per next_kernel pulse; the PE
// holds its weights (kernel_rf_en=1) in between.
// Optional feature: define KERNEL_PREFETCH_EN to prefetch the next kernel
// into a shadow buffer while waiting, so it streams out one cycle after
// next_kernel without touching SRAM.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   load_valid/load_ready            : run request handshake (ready only in IDLE)
//   load_base, load_cnt              : first weight address, kernel count
//   next_kernel                      : PE finished current kernel (used in WAIT)
//   kernel_loaded, done              : single-cycle status pulses
//   sram_ren, sram_addr, sram_rdata  : weight SRAM read port (1-cycle latency)
//   kernel_rf_en, kernel_data        : PE load port (0 = PE captures data)
module kernel_feeder
    import cnn_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [ADDR_W-1:0]          load_base,
    input  logic [CNT_W-1:0]           load_cnt,
    input  logic                       next_kernel,
    output logic                       kernel_loaded,
    output logic                       done,
    output logic                       sram_ren,
    output logic [ADDR_W-1:0]          sram_addr,
    input  logic [WEIGHT_W-1:0]        sram_rdata,
    output logic                       kernel_rf_en,
    output logic signed [WEIGHT_W-1:0] kernel_data
);

    localparam logic [TAP_W-1:0] TAPS        = TAP_W'(KERNEL_TAPS);
    // Direct fetch: 9 read cycles + 1 SRAM latency + 1 register stage.
    localparam logic [TAP_W-1:0] DIRECT_LAST = TAP_W'(KERNEL_TAPS + 1);
    // Buffered stream: tap 0 is presented from WAIT, taps 1..8 from FETCH.
    localparam logic [TAP_W-1:0] BUF_LAST    = TAP_W'(KERNEL_TAPS);

    feeder_state_t state, state_nxt;

    logic [TAP_W-1:0]    tap_q;
    logic [CNT_W-1:0]    k_q, cnt_q, k_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic                ren_d1_q;

    logic                accept;
    logic                fetch_end;
    logic                resume;
    logic                from_buf;
    logic                wait_read;
    logic                kick;
    logic [TAP_W-1:0]    resume_tap;
    logic                present;
    logic [WEIGHT_W-1:0] present_data;

    assign k_nxt     = k_q + 1'b1;
    assign sram_addr = addr_q;

`ifdef KERNEL_PREFETCH_EN
    logic                from_buf_q;
    logic                pending_q;
    logic [TAP_W-1:0]    pf_issue_q;
    logic [TAP_W-1:0]    pf_wr_q;
    logic                pf_rd_d1_q;
    logic                buf_ready;
    logic                stream;
    logic [TAP_W-1:0]    buf_rd_idx;
    logic [WEIGHT_W-1:0] buf_rd_data;

    // Buffer counts as full in the cycle of its last write so streaming can
    // begin on the very next cycle.
    assign buf_ready  = (pf_wr_q == TAPS) || (pf_rd_d1_q && (pf_wr_q == TAPS - 1'b1));
    assign kick       = (next_kernel || pending_q) && buf_ready;
    assign wait_read  = (pf_issue_q < TAPS);
    assign from_buf   = from_buf_q;
    assign resume_tap = TAP_W'(1);
    assign stream     = resume || ((state == S_FETCH) && from_buf_q && (tap_q < TAPS));
    assign buf_rd_idx = (state == S_FETCH) ? tap_q : '0;
    assign present      = ren_d1_q || stream;
    assign present_data = stream ? buf_rd_data : sram_rdata;

    kernel_shadow_buf u_shadow (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pf_rd_d1_q),
        .wr_idx  (pf_wr_q),
        .wr_data (sram_rdata),
        .rd_idx  (buf_rd_idx),
        .rd_data (buf_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            from_buf_q <= 1'b0;
            pending_q  <= 1'b0;
            pf_issue_q <= '0;
            pf_wr_q    <= '0;
            pf_rd_d1_q <= 1'b0;
        end else begin
            pf_rd_d1_q <= (state == S_WAIT) && sram_ren;
            if (accept) begin
                from_buf_q <= 1'b0;
                pending_q  <= 1'b0;
            end else if (resume) begin
                from_buf_q <= 1'b1;
                pending_q  <= 1'b0;
            end else if ((state == S_WAIT) && next_kernel) begin
                pending_q  <= 1'b1;
            end
            if (fetch_end) begin
                pf_issue_q <= '0;
                pf_wr_q    <= '0;
            end else begin
                if ((state == S_WAIT) && sram_ren) pf_issue_q <= pf_issue_q + 1'b1;
                if (pf_rd_d1_q)                    pf_wr_q    <= pf_wr_q + 1'b1;
            end
        end
    end
`else
    assign kick         = next_kernel;
    assign wait_read    = 1'b0;
    assign from_buf     = 1'b0;
    assign resume_tap   = '0;
    assign present      = ren_d1_q;
    assign present_data = sram_rdata;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        sram_ren   = 1'b0;
        accept     = 1'b0;
        fetch_end  = 1'b0;
        resume     = 1'b0;
        case (state)
            S_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    accept    = 1'b1;
                    state_nxt = (load_cnt == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                sram_ren = !from_buf && (tap_q < TAPS);
                if (tap_q == (from_buf ? BUF_LAST : DIRECT_LAST)) begin
                    fetch_end = 1'b1;
                    state_nxt = (k_nxt == cnt_q) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                sram_ren = wait_read;
                if (kick) begin
                    resume    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_q         <= '0;
            k_q           <= '0;
            cnt_q         <= '0;
            addr_q        <= '0;
            ren_d1_q      <= 1'b0;
            kernel_data   <= '0;
            kernel_rf_en  <= 1'b1;
            kernel_loaded <= 1'b0;
            done          <= 1'b0;
        end else begin
            ren_d1_q      <= (state == S_FETCH) && sram_ren;
            kernel_loaded <= fetch_end;
            done          <= (state == S_DONE);
            kernel_rf_en  <= !present;
            if (present) kernel_data <= present_data;

            // Address pointer runs straight through a run: after kernel k's
            // nine reads it already sits at base + 9*(k+1).
            if (accept) begin
                addr_q <= load_base;
                cnt_q  <= load_cnt;
                k_q    <= '0;
            end else if (sram_ren) begin
                addr_q <= addr_q + 1'b1;
            end

            if (fetch_end) k_q <= k_nxt;

            if (accept)                tap_q <= '0;
            else if (resume)           tap_q <= resume_tap;
            else if (state == S_FETCH) tap_q <= tap_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_kernel_feeder.sv
module tb_kernel_feeder;

    localparam int H = 256;
`ifdef KERNEL_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               load_valid;
    logic               load_ready;
    logic [11:0]        load_base;
    logic [7:0]         load_cnt;
    logic               next_kernel;
    logic               kernel_loaded;
    logic               done;
    logic               sram_ren;
    logic [11:0]        sram_addr;
    logic [15:0]        sram_rdata;
    logic               kernel_rf_en;
    logic signed [15:0] kernel_data;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [4096];
    logic [15:0] last_w;

    // Expected per-cycle timeline, index = cycles after request acceptance.
    bit          e_ren [H];
    logic [11:0] e_addr[H];
    bit          e_rf  [H];
    logic [15:0] e_w   [H];
    bit          e_ld  [H];
    bit          e_dn  [H];
    bit          nk_at [H];
    int          done_n;

    kernel_feeder #(.ADDR_W(12), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_base     (load_base),
        .load_cnt      (load_cnt),
        .next_kernel   (next_kernel),
        .kernel_loaded (kernel_loaded),
        .done          (done),
        .sram_ren      (sram_ren),
        .sram_addr     (sram_addr),
        .sram_rdata    (sram_rdata),
        .kernel_rf_en  (kernel_rf_en),
        .kernel_data   (kernel_data)
    );

    always #5 clk = ~clk;

    // Weight SRAM: data valid one cycle after the read enable.
    always @(posedge clk) if (sram_ren) sram_rdata <= mem[sram_addr];

    // Build the expected timeline from the run rules: direct kernels read at
    // s..s+8 and present at s+2..s+10; prefetched kernels read during WAIT
    // from the loaded cycle and present on y+1..y+9, y = max(next, last write).
    task automatic build_expect(input logic [11:0] base, input int cnt, input int d);
        int s, l, w, y;
        logic [11:0] a;
        for (int n = 0; n < H; n++) begin
            e_ren[n] = 0; e_addr[n] = '0; e_rf[n] = 1; e_w[n] = '0;
            e_ld[n] = 0; e_dn[n] = 0; nk_at[n] = 0;
        end
        done_n = 2;
        if (cnt == 0) begin
            e_dn[2] = 1;
            return;
        end
        s = 1; y = 0;
        for (int j = 0; j < cnt; j++) begin
            for (int i = 0; i < 9; i++) begin
                a = base + 12'(9 * j + i);
                if (j == 0 || !PF) begin
                    e_ren[s + i] = 1; e_addr[s + i] = a;
                    e_rf[s + 2 + i] = 0; e_w[s + 2 + i] = mem[a];
                end else begin
                    e_rf[y + 1 + i] = 0; e_w[y + 1 + i] = mem[a];
                end
            end
            l = (j == 0 || !PF) ? s + 11 : y + 10;
            e_ld[l] = 1;
            if (j == cnt - 1) begin
                e_dn[l + 1] = 1;
                done_n = l + 1;
            end else begin
                w = l + d;
                nk_at[w] = 1;
                if (PF) begin
                    for (int i = 0; i < 9; i++) begin
                        e_ren[l + i]  = 1;
                        e_addr[l + i] = base + 12'(9 * (j + 1) + i);
                    end
                    y = (w > l + 9) ? w : l + 9;
                end else begin
                    s = w + 1;
                end
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [11:0] base, input int cnt,
                             input int d, input bit junk);
        logic [15:0] cur;
        build_expect(base, cnt, d);
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_at_request got=%b exp=1", tag, load_ready);
        end
        load_base  = base;
        load_cnt   = 8'(cnt);
        load_valid = 1'b1;
        cur = last_w;
        for (int n = 1; n <= done_n + 2; n++) begin
            @(negedge clk);
            load_valid  = 1'b0;
            next_kernel = 1'b0;
            if (!e_rf[n]) cur = e_w[n];
            checks++;
            if (sram_ren !== e_ren[n]) begin
                failures++;
                $display("FAIL %s sram_ren n=%0d got=%b exp=%b", tag, n, sram_ren, e_ren[n]);
            end
            if (e_ren[n]) begin
                checks++;
                if (sram_addr !== e_addr[n]) begin
                    failures++;
                    $display("FAIL %s sram_addr n=%0d got=%h exp=%h", tag, n, sram_addr, e_addr[n]);
                end
            end
            checks++;
            if (kernel_rf_en !== e_rf[n]) begin
                failures++;
                $display("FAIL %s kernel_rf_en n=%0d got=%b exp=%b", tag, n, kernel_rf_en, e_rf[n]);
            end
            checks++;
            if (kernel_data !== cur) begin
                failures++;
                $display("FAIL %s kernel_data n=%0d got=%h exp=%h", tag, n, kernel_data, cur);
            end
            checks++;
            if (kernel_loaded !== e_ld[n]) begin
                failures++;
                $display("FAIL %s kernel_loaded n=%0d got=%b exp=%b", tag, n, kernel_loaded, e_ld[n]);
            end
            checks++;
            if (done !== e_dn[n]) begin
                failures++;
                $display("FAIL %s done n=%0d got=%b exp=%b", tag, n, done, e_dn[n]);
            end
            if (n != done_n) begin
                checks++;
                if (load_ready !== (n > done_n)) begin
                    failures++;
                    $display("FAIL %s load_ready n=%0d got=%b exp=%b", tag, n, load_ready, (n > done_n));
                end
            end
            if (nk_at[n]) next_kernel = 1'b1;
            if (junk && n == 5) begin
                load_valid  = 1'b1;
                load_base   = ~base;
                load_cnt    = 8'd3;
                next_kernel = 1'b1;
            end
        end
        last_w = cur;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({kernel_rf_en, load_ready, sram_ren, kernel_loaded, done} !== 5'b11000) begin
            failures++;
            $display("FAIL reset flags got=%b exp=11000",
                     {kernel_rf_en, load_ready, sram_ren, kernel_loaded, done});
        end
        checks++;
        if (kernel_data !== 16'sd0 || sram_addr !== 12'h000) begin
            failures++;
            $display("FAIL reset data_addr got=%h/%h exp=0000/000", kernel_data, sram_addr);
        end
        rst = 1'b0;
        last_w = '0;
        @(negedge clk);
    endtask

    task automatic test_single_kernel();
        for (int i = 0; i < 9; i++) mem[12'h010 + i] = 16'(i + 1);
        run_check("single", 12'h010, 1, 0, 1'b0);
    endtask

    task automatic test_run_of_three();
        run_check("run3", 12'(100 + $urandom_range(0, 3000)), 3, 5, 1'b0);
    endtask

    task automatic test_address_wrap();
        run_check("wrap", 12'hFFC, 1, 0, 1'b0);
    endtask

    task automatic test_zero_count();
        run_check("zero", 12'h123, 0, 0, 1'b0);
    endtask

    task automatic test_ignored_inputs();
        run_check("ignored", 12'(1000 + $urandom_range(0, 1000)), 1, 0, 1'b1);
    endtask

    task automatic test_mid_run_reset();
        load_base  = 12'h200;
        load_cnt   = 8'd2;
        load_valid = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            load_valid = 1'b0;
        end
        // cycle 6 carries the 4th weight
        checks++;
        if (kernel_rf_en !== 1'b0) begin
            failures++;
            $display("FAIL midreset pre_rf_en got=%b exp=0", kernel_rf_en);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({kernel_rf_en, load_ready, sram_ren, kernel_loaded, done} !== 5'b11000
            || kernel_data !== 16'sd0) begin
            failures++;
            $display("FAIL midreset immediate got=%b data=%h exp=11000 data=0000",
                     {kernel_rf_en, load_ready, sram_ren, kernel_loaded, done}, kernel_data);
        end
        @(negedge clk);
        rst = 1'b0;
        last_w = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || sram_ren !== 1'b0 || load_ready !== 1'b1 || kernel_rf_en !== 1'b1) begin
                failures++;
                $display("FAIL midreset after n=%0d done=%b ren=%b ready=%b rf=%b exp 0 0 1 1",
                         n, done, sram_ren, load_ready, kernel_rf_en);
            end
        end
    endtask

    task automatic test_prefetch();
        // next_kernel soon after kernel_loaded (pending in prefetch builds)
        // and well after it.
        run_check("nk_early", 12'(2000 + $urandom_range(0, 1000)), 3, 2, 1'b0);
        run_check("nk_late", 12'(50 + $urandom_range(0, 1000)), 2, 12, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            run_check("random", 12'($urandom_range(0, 4095)), $urandom_range(1, 4),
                      $urandom_range(0, 6), 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        rst         = 1'b1;
        load_valid  = 1'b0;
        load_base   = '0;
        load_cnt    = '0;
        next_kernel = 1'b0;
        last_w      = '0;
        @(negedge clk);
        test_reset();
        test_single_kernel();
        test_run_of_three();
        test_address_wrap();
        test_zero_count();
        test_ignored_inputs();
        test_mid_run_reset();
        test_prefetch();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
